skew_deskew_registers: RTL

- Generalised per-lane delay block for the systolic array edges.
- In skew mode, lane i is delayed by i*STRIDE cycles; this staggers activations and weights on entry to the array.
- In deskew mode, lane i is delayed by (N-1-i)*STRIDE cycles; this re-aligns results leaving the array.
- Each lane carries a valid bit with its data. The block supports stall, flush and a safe drain-then-switch mode change with a ready handshake.

---
 rtl/skew_deskew_registers_if.sv | 32 +++
 rtl/skew_deskew_registers.sv | 137 +++++++++++++
 2 files changed

// File: rtl/skew_deskew_registers_if.sv
`default_nettype none
// ============================================================================
// Module      : skew_deskew_registers_if
// Description : Lane bus and control bundle for the skew/deskew delay block.
// Revision    : 1.0 - initial release
// ============================================================================
interface skew_deskew_registers_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
);
    logic                  en;
    logic                  flush;
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_WIDTH-1:0] din;
    logic [N*DATA_WIDTH-1:0] dout;
    logic [N-1:0]          dout_valid;
    logic                  mode_q;
    logic                  draining;

    modport master (
        output en, flush, mode, in_valid, din,
        input  in_ready, dout, dout_valid, mode_q, draining
    );

    modport slave (
        input  en, flush, mode, in_valid, din,
        output in_ready, dout, dout_valid, mode_q, draining
    );
endinterface
`default_nettype wire

// File: rtl/skew_deskew_registers.sv
`default_nettype none
// ============================================================================
// Module      : skew_deskew_registers
// Description : Per-lane {data,valid} delay lines with skew/deskew taps and a
//               drain-then-switch mode change.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_deskew_registers #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int STRIDE     = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    skew_deskew_registers_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_mode_q;
    logic                    w_latch_mode;
    logic                    w_in_ready;
    logic                    w_draining;
    logic                    w_accept;
    logic [N-1:0]            w_lane_busy;
    logic [N*DATA_WIDTH-1:0] w_dout;
    logic [N-1:0]            w_dout_valid;

    assign w_accept = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_mode_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_mode) begin
                r_mode_q <= bus.mode;
            end
        end
    end

    // A pending mode request blocks input; the switch lands once no valid bit
    // remains anywhere, so no word ever sees two different tap settings.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_draining   = 1'b0;
        w_latch_mode = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = (bus.mode == r_mode_q);
                if (bus.mode != r_mode_q) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_draining = 1'b1;
                if (bus.en && (w_lane_busy == '0)) begin
                    w_latch_mode = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int C_D_SKEW   = gi * STRIDE;
        localparam int C_D_DESKEW = (N - 1 - gi) * STRIDE;
        // Stages past the deeper of the two taps are never observed, so each
        // lane stops there; lanes 0 and N-1 still span the full depth.
        localparam int C_DEPTH    = (C_D_SKEW > C_D_DESKEW) ? C_D_SKEW : C_D_DESKEW;

        logic [DATA_WIDTH-1:0] r_data [C_DEPTH];
        logic [C_DEPTH-1:0]    r_valid;
        logic [DATA_WIDTH-1:0] w_din;
        logic [DATA_WIDTH-1:0] w_skew_data;
        logic [DATA_WIDTH-1:0] w_deskew_data;
        logic                  w_skew_valid;
        logic                  w_deskew_valid;

        assign w_din = bus.din[gi*DATA_WIDTH +: DATA_WIDTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < C_DEPTH; k++) begin
                    r_data[k] <= '0;
                end
                r_valid <= '0;
            end else if (bus.flush) begin
                r_valid <= '0;
            end else if (bus.en) begin
                r_data[0]  <= w_din;
                r_valid[0] <= w_accept;
                for (int k = 1; k < C_DEPTH; k++) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        assign w_lane_busy[gi] = |r_valid;

        if (C_D_SKEW == 0) begin : g_skew_pass
            assign w_skew_data  = w_din;
            assign w_skew_valid = w_accept;
        end else begin : g_skew_tap
            assign w_skew_data  = r_data[C_D_SKEW-1];
            assign w_skew_valid = r_valid[C_D_SKEW-1];
        end

        if (C_D_DESKEW == 0) begin : g_deskew_pass
            assign w_deskew_data  = w_din;
            assign w_deskew_valid = w_accept;
        end else begin : g_deskew_tap
            assign w_deskew_data  = r_data[C_D_DESKEW-1];
            assign w_deskew_valid = r_valid[C_D_DESKEW-1];
        end

        assign w_dout[gi*DATA_WIDTH +: DATA_WIDTH] = r_mode_q ? w_deskew_data : w_skew_data;
        assign w_dout_valid[gi] = r_mode_q ? w_deskew_valid : w_skew_valid;
    end

    assign bus.dout       = w_dout;
    assign bus.dout_valid = w_dout_valid;
    assign bus.in_ready   = w_in_ready;
    assign bus.mode_q     = r_mode_q;
    assign bus.draining   = w_draining;

endmodule
`default_nettype wire
